// File: rtl/lenet_pkg.sv
// Shared LeNet types and constants: datapath widths, FC1 geometry and the FC FSM state encoding.
package lenet_pkg;

  localparam int DATA_W       = 16;
  localparam int FRAC_W       = 8;
  localparam int LANES        = 64;
  localparam int FC1_WORDS    = 7;
  localparam int FC1_NEURONS  = 120;
  localparam int ACC_W        = 40;
  localparam int DRAIN_CYCLES = 4;

  // A Q8.8 x Q8.8 product realigned to Q8.8 keeps 24 significant bits.
  localparam int PROD_W = 2*DATA_W - FRAC_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } fc_state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-32768);

  function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W:0] v);
    logic [DATA_W-1:0] r;
    if (v > SAT_MAX)
      r = 16'h7FFF;
    else if (v < SAT_MIN)
      r = 16'h8000;
    else
      r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fc_1_dot64.sv
// 64-lane signed Q8.8 dot product: registered lane products, then a registered sum of all lanes.
module fc_1_dot64
  import lenet_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [LANES*DATA_W-1:0]      fm_word,
  input  logic [LANES*DATA_W-1:0]      w_word,
  output logic                         out_valid,
  output logic signed [SUM_W-1:0]      sum
);

  logic [LANES*PROD_W-1:0]   prod_flat;
  logic signed [PROD_W-1:0]  prod_reg [LANES];
  logic                      prod_valid_reg;
  logic signed [SUM_W-1:0]   tree_sum;
  logic signed [SUM_W-1:0]   sum_reg;
  logic                      sum_valid_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0]   a;
      logic signed [DATA_W-1:0]   b;
      logic signed [2*DATA_W-1:0] full;
      assign a    = fm_word[gi*DATA_W +: DATA_W];
      assign b    = w_word[gi*DATA_W +: DATA_W];
      assign full = a * b;
      // Dropping the low FRAC_W bits of the signed product is the arithmetic shift right by 8.
      assign prod_flat[gi*PROD_W +: PROD_W] = full[2*DATA_W-1:FRAC_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) prod_reg[i] <= '0;
      prod_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) prod_reg[i] <= $signed(prod_flat[i*PROD_W +: PROD_W]);
      prod_valid_reg <= in_valid;
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + SUM_W'(prod_reg[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
    end else begin
      sum_reg       <= tree_sum;
      sum_valid_reg <= prod_valid_reg;
    end
  end

  assign sum       = sum_reg;
  assign out_valid = sum_valid_reg;

endmodule

// File: rtl/fc_1.sv
// FC1 layer: 400->120 fully connected Q8.8 layer streaming 7 words per neuron through a 64-lane MAC.
// Optional ReLU on the written result is enabled by defining FC_1_RELU_EN.
module fc_1
  import lenet_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fc_1_en,
  output logic                     fm_bram_0_enb,
  output logic [5:0]               fm_bram_0_addrb,
  input  logic [LANES*DATA_W-1:0]  fm_bram_0_doutb,
  output logic                     w_bram_ena,
  output logic [9:0]               w_bram_addra,
  input  logic [LANES*DATA_W-1:0]  w_bram_douta,
  output logic [6:0]               b_bram_addra,
  input  logic [DATA_W-1:0]        b_bram_douta,
  output logic                     fc_bram_wea,
  output logic [6:0]               fc_bram_addra,
  output logic [DATA_W-1:0]        fc_bram_dina,
  output logic                     fc_1_finish
);

  localparam logic [2:0] W_LAST = 3'(FC1_WORDS - 1);
  localparam logic [6:0] N_LAST = 7'(FC1_NEURONS - 1);
  localparam logic [1:0] D_LAST = 2'(DRAIN_CYCLES - 1);

  fc_state_t   state_reg, state_next;
  logic [2:0]  w_reg, w_next;
  logic [6:0]  n_reg, n_next;
  logic [1:0]  drain_reg, drain_next;

  // Output and issue-side registers; their next values are decoded from the next state so
  // every port is a flop and the address appears in the cycle the state is entered.
  logic              rd_en_reg, rd_en_next;
  logic [5:0]        fm_addr_reg, fm_addr_next;
  logic [9:0]        w_addr_reg, w_addr_next;
  logic [6:0]        b_addr_reg, b_addr_next;
  logic              first_reg, first_next;
  logic              bias_issue_reg, bias_issue_next;
  logic              wea_reg, wea_next;
  logic [6:0]        fc_addr_reg, fc_addr_next;
  logic [DATA_W-1:0] dina_reg, dina_next;
  logic              finish_reg, finish_next;

  logic                     rd_d1_reg;
  logic                     first_d1_reg, first_d2_reg, first_d3_reg;
  logic                     bias_d1_reg;
  logic signed [DATA_W-1:0] bias_reg;
  logic signed [ACC_W-1:0]  acc_reg;

  logic                     dot_valid;
  logic signed [SUM_W-1:0]  dot_sum;
  logic signed [ACC_W:0]    acc_bias;
  logic [DATA_W-1:0]        sat_val;
  logic [DATA_W-1:0]        result;

  always_comb begin
    state_next = state_reg;
    w_next     = w_reg;
    n_next     = n_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE: begin
        if (fc_1_en) begin
          state_next = RUN;
          w_next     = '0;
          n_next     = '0;
        end
      end
      RUN: begin
        if (w_reg == W_LAST) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          w_next = w_reg + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_reg == D_LAST) state_next = WRITE;
        else                     drain_next = drain_reg + 2'd1;
      end
      WRITE: begin
        if (n_reg == N_LAST) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
          n_next     = n_reg + 7'd1;
          w_next     = '0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_en_next      = 1'b0;
    fm_addr_next    = fm_addr_reg;
    w_addr_next     = w_addr_reg;
    b_addr_next     = b_addr_reg;
    first_next      = 1'b0;
    bias_issue_next = 1'b0;
    wea_next        = 1'b0;
    fc_addr_next    = fc_addr_reg;
    dina_next       = dina_reg;
    finish_next     = 1'b0;
    if (state_next == RUN) begin
      rd_en_next   = 1'b1;
      fm_addr_next = 6'(w_next);
      w_addr_next  = 10'(n_next) * 10'(FC1_WORDS) + 10'(w_next);
      first_next   = (w_next == 3'd0);
      if (w_next == W_LAST) begin
        b_addr_next     = n_next;
        bias_issue_next = 1'b1;
      end
    end
    if (state_next == WRITE) begin
      wea_next     = 1'b1;
      fc_addr_next = n_next;
      dina_next    = result;
    end
    if (state_next == DONE) finish_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      w_reg          <= '0;
      n_reg          <= '0;
      drain_reg      <= '0;
      rd_en_reg      <= 1'b0;
      fm_addr_reg    <= '0;
      w_addr_reg     <= '0;
      b_addr_reg     <= '0;
      first_reg      <= 1'b0;
      bias_issue_reg <= 1'b0;
      wea_reg        <= 1'b0;
      fc_addr_reg    <= '0;
      dina_reg       <= '0;
      finish_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      w_reg          <= w_next;
      n_reg          <= n_next;
      drain_reg      <= drain_next;
      rd_en_reg      <= rd_en_next;
      fm_addr_reg    <= fm_addr_next;
      w_addr_reg     <= w_addr_next;
      b_addr_reg     <= b_addr_next;
      first_reg      <= first_next;
      bias_issue_reg <= bias_issue_next;
      wea_reg        <= wea_next;
      fc_addr_reg    <= fc_addr_next;
      dina_reg       <= dina_next;
      finish_reg     <= finish_next;
    end
  end

  // Tag pipeline: BRAM data lands one cycle after the address, the dot product adds two more.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_d1_reg    <= 1'b0;
      first_d1_reg <= 1'b0;
      first_d2_reg <= 1'b0;
      first_d3_reg <= 1'b0;
      bias_d1_reg  <= 1'b0;
      bias_reg     <= '0;
    end else begin
      rd_d1_reg    <= rd_en_reg;
      first_d1_reg <= first_reg;
      first_d2_reg <= first_d1_reg;
      first_d3_reg <= first_d2_reg;
      bias_d1_reg  <= bias_issue_reg;
      if (bias_d1_reg) bias_reg <= $signed(b_bram_douta);
    end
  end

  fc_1_dot64 u_dot64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_d1_reg),
    .fm_word   (fm_bram_0_doutb),
    .w_word    (w_bram_douta),
    .out_valid (dot_valid),
    .sum       (dot_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (dot_valid) begin
      if (first_d3_reg) acc_reg <= ACC_W'(dot_sum);
      else              acc_reg <= acc_reg + ACC_W'(dot_sum);
    end
  end

  assign acc_bias = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(bias_reg);
  assign sat_val  = sat16(acc_bias);

`ifdef FC_1_RELU_EN
  assign result = sat_val[DATA_W-1] ? '0 : sat_val;
`else
  assign result = sat_val;
`endif

  assign fm_bram_0_enb   = rd_en_reg;
  assign fm_bram_0_addrb = fm_addr_reg;
  assign w_bram_ena      = rd_en_reg;
  assign w_bram_addra    = w_addr_reg;
  assign b_bram_addra    = b_addr_reg;
  assign fc_bram_wea     = wea_reg;
  assign fc_bram_addra   = fc_addr_reg;
  assign fc_bram_dina    = dina_reg;
  assign fc_1_finish     = finish_reg;

endmodule

// File: tb/tb_fc_1.sv
// Directed bench for fc_1: BRAM models, logged reads/writes and per-run timing/data checks.
module tb_fc_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          fc_1_en;
  logic          fm_bram_0_enb;
  logic [5:0]    fm_bram_0_addrb;
  logic [1023:0] fm_bram_0_doutb;
  logic          w_bram_ena;
  logic [9:0]    w_bram_addra;
  logic [1023:0] w_bram_douta;
  logic [6:0]    b_bram_addra;
  logic [15:0]   b_bram_douta;
  logic          fc_bram_wea;
  logic [6:0]    fc_bram_addra;
  logic [15:0]   fc_bram_dina;
  logic          fc_1_finish;

  fc_1 dut (
    .clk             (clk),
    .rst             (rst),
    .fc_1_en         (fc_1_en),
    .fm_bram_0_enb   (fm_bram_0_enb),
    .fm_bram_0_addrb (fm_bram_0_addrb),
    .fm_bram_0_doutb (fm_bram_0_doutb),
    .w_bram_ena      (w_bram_ena),
    .w_bram_addra    (w_bram_addra),
    .w_bram_douta    (w_bram_douta),
    .b_bram_addra    (b_bram_addra),
    .b_bram_douta    (b_bram_douta),
    .fc_bram_wea     (fc_bram_wea),
    .fc_bram_addra   (fc_bram_addra),
    .fc_bram_dina    (fc_bram_dina),
    .fc_1_finish     (fc_1_finish)
  );

  logic [1023:0] fm_mem [0:63];
  logic [1023:0] w_mem  [0:1023];
  logic [15:0]   b_mem  [0:127];

  always @(posedge clk) begin
    if (fm_bram_0_enb) fm_bram_0_doutb <= fm_mem[fm_bram_0_addrb];
    if (w_bram_ena)    w_bram_douta    <= w_mem[w_bram_addra];
    b_bram_douta <= b_mem[b_bram_addra];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         rd_total = 0, wr_total = 0, fin_total = 0;
  int         rd_cyc [8192];
  logic [5:0] rd_fm  [8192];
  logic [9:0] rd_w   [8192];
  logic [6:0] rd_b   [8192];
  logic       rd_both[8192];
  int         wr_cyc [1024];
  logic [6:0] wr_addr[1024];
  logic [15:0] wr_data[1024];
  int         fin_cyc[64];

  always @(negedge clk) begin
    if (fm_bram_0_enb || w_bram_ena) begin
      if (rd_total < 8192) begin
        rd_cyc[rd_total]  = cyc;
        rd_fm[rd_total]   = fm_bram_0_addrb;
        rd_w[rd_total]    = w_bram_addra;
        rd_b[rd_total]    = b_bram_addra;
        rd_both[rd_total] = fm_bram_0_enb && w_bram_ena;
      end
      rd_total = rd_total + 1;
    end
    if (fc_bram_wea) begin
      if (wr_total < 1024) begin
        wr_cyc[wr_total]  = cyc;
        wr_addr[wr_total] = fc_bram_addra;
        wr_data[wr_total] = fc_bram_dina;
      end
      wr_total = wr_total + 1;
    end
    if (fc_1_finish) begin
      if (fin_total < 64) fin_cyc[fin_total] = cyc;
      fin_total = fin_total + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_val [120];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1023:0] splat(input logic [15:0] v);
    logic [1023:0] r;
    for (int i = 0; i < 64; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  task automatic clear_mems();
    for (int a = 0; a < 64; a++)   fm_mem[a] = '0;
    for (int a = 0; a < 1024; a++) w_mem[a]  = '0;
    for (int a = 0; a < 128; a++)  b_mem[a]  = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_fm_enb"},  32'(fm_bram_0_enb),   32'd0);
    check({tag, "_fm_addr"}, 32'(fm_bram_0_addrb), 32'd0);
    check({tag, "_w_ena"},   32'(w_bram_ena),      32'd0);
    check({tag, "_w_addr"},  32'(w_bram_addra),    32'd0);
    check({tag, "_b_addr"},  32'(b_bram_addra),    32'd0);
    check({tag, "_wea"},     32'(fc_bram_wea),     32'd0);
    check({tag, "_fc_addr"}, 32'(fc_bram_addra),   32'd0);
    check({tag, "_dina"},    32'(fc_bram_dina),    32'd0);
    check({tag, "_finish"},  32'(fc_1_finish),     32'd0);
  endtask

  // One full layer run; en is high for cycle 0 and again for one cycle at pulse_at (0 = never).
  task automatic run_and_check(input string name, input int pulse_at);
    int rb, wb, fb, t0, bad, cnt, n, w;
    @(negedge clk);
    rb = rd_total; wb = wr_total; fb = fin_total;
    fc_1_en = 1'b1;
    t0 = cyc;
    for (int i = 1; i <= 1460; i++) begin
      @(negedge clk);
      fc_1_en = (i == pulse_at);
    end
    fc_1_en = 1'b0;

    cnt = rd_total - rb;
    check({name, "_reads"}, 32'(cnt), 32'd840);
    bad = 0;
    for (int k = 0; k < cnt && k < 840; k++) begin
      n = k / 7; w = k % 7;
      if (rd_cyc[rb+k] != t0 + 1 + 12*n + w) bad++;
      if (rd_fm[rb+k] != 6'(w)) bad++;
      if (rd_w[rb+k] != 10'(n*7 + w)) bad++;
      if (!rd_both[rb+k]) bad++;
      if (w == 6 && rd_b[rb+k] != 7'(n)) bad++;
    end
    check({name, "_read_seq"}, 32'(bad), 32'd0);

    cnt = wr_total - wb;
    check({name, "_writes"}, 32'(cnt), 32'd120);
    if (cnt > 0) begin
      check({name, "_first_wr_cyc"},  32'(wr_cyc[wb] - t0), 32'd12);
      check({name, "_first_wr_addr"}, 32'(wr_addr[wb]),     32'd0);
    end
    if (cnt >= 120) begin
      check({name, "_last_wr_cyc"},  32'(wr_cyc[wb+119] - t0), 32'd1440);
      check({name, "_last_wr_addr"}, 32'(wr_addr[wb+119]),     32'd119);
    end
    bad = 0;
    for (int k = 0; k < cnt && k < 120; k++) begin
      if (wr_cyc[wb+k] - t0 != 12 + 12*k) bad++;
      if (wr_addr[wb+k] != 7'(k)) bad++;
      check($sformatf("%s_data_n%0d", name, k), 32'(wr_data[wb+k]), 32'(exp_val[k]));
    end
    check({name, "_write_timing"}, 32'(bad), 32'd0);

    check({name, "_finish_count"}, 32'(fin_total - fb), 32'd1);
    if (fin_total > fb) check({name, "_finish_cyc"}, 32'(fin_cyc[fb] - t0), 32'd1441);
    $display("run %s: reads=%0d writes=%0d finishes=%0d", name, rd_total - rb, wr_total - wb, fin_total - fb);
  endtask

  initial begin
    int rb, wb, fb, t0;
    rst = 1'b1;
    fc_1_en = 1'b0;
    clear_mems();
    fm_bram_0_doutb = '0;
    w_bram_douta = '0;
    b_bram_douta = '0;

    // Reset state, with en held high to show reset wins.
    repeat (2) @(negedge clk);
    fc_1_en = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset");
    fc_1_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset_enb", 32'(fm_bram_0_enb), 32'd0);

    // All ones: 448.0 saturates to 0x7FFF.
    for (int a = 0; a < 7; a++)   fm_mem[a] = splat(16'h0100);
    for (int a = 0; a < 840; a++) w_mem[a]  = splat(16'h0100);
    for (int n = 0; n < 120; n++) exp_val[n] = 16'h7FFF;
    run_and_check("ones", 0);

    // Single lane: 2.0 * 0.5 + 0.0625 = 0x0110.
    clear_mems();
    fm_mem[0][15:0] = 16'h0200;
    for (int n = 0; n < 120; n++) begin
      w_mem[n*7][15:0] = 16'h0080;
      b_mem[n] = 16'h0010;
      exp_val[n] = 16'h0110;
    end
    run_and_check("lane0", 0);

    // Every lane of every word contributes 1 LSB * k; bias n distinguishes neurons.
    clear_mems();
    for (int a = 0; a < 7; a++) fm_mem[a] = splat(16'h0010);
    for (int n = 0; n < 120; n++) begin
      for (int w = 0; w < 7; w++) w_mem[n*7+w] = splat(16'((n % 4 + 1) * 16));
      b_mem[n] = 16'(n);
      exp_val[n] = 16'(448 * (n % 4 + 1) + n);
    end
    run_and_check("spread", 0);

    // en pulsed mid-RUN must not disturb anything.
    run_and_check("en_pulse", 5);

    // Negative result of -3.0.
    clear_mems();
    fm_mem[0][15:0] = 16'h0100;
    for (int n = 0; n < 120; n++) begin
      w_mem[n*7][15:0] = 16'hFD00;
`ifdef FC_1_RELU_EN
      exp_val[n] = 16'h0000;
`else
      exp_val[n] = 16'hFD00;
`endif
    end
    run_and_check("negative", 0);

    // Reset at cycle 300 aborts the run.
    clear_mems();
    for (int a = 0; a < 7; a++) fm_mem[a] = splat(16'h0010);
    for (int n = 0; n < 120; n++) begin
      for (int w = 0; w < 7; w++) w_mem[n*7+w] = splat(16'((n % 4 + 1) * 16));
      b_mem[n] = 16'(n);
      exp_val[n] = 16'(448 * (n % 4 + 1) + n);
    end
    @(negedge clk);
    rb = rd_total; wb = wr_total; fb = fin_total;
    fc_1_en = 1'b1;
    t0 = cyc;
    @(negedge clk);
    fc_1_en = 1'b0;
    repeat (299) @(negedge clk);
    check("abort_at_cycle", 32'(cyc - t0), 32'd300);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("abort");
    rst = 1'b0;
    repeat (1500) @(negedge clk);
    check("abort_writes", 32'(wr_total - wb), 32'd25);
    check("abort_reads", 32'(rd_total - rb), 32'd175);
    check("abort_finish", 32'(fin_total - fb), 32'd0);
    $display("run abort: reads=%0d writes=%0d finishes=%0d", rd_total - rb, wr_total - wb, fin_total - fb);

    run_and_check("restart", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
